// File: rtl/cirno_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cirno_pkg
// Description : Shared instruction-set definitions: op codes, ALU funct
//               codes, encoding field prefixes and encoder state encoding.
//               Used by the encoder and by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cirno_pkg;

  // Op codes presented on the instruction-field interface
  typedef enum logic [3:0] {
    OP_NIL   = 4'd0,
    OP_HALT  = 4'd1,
    OP_JMPI  = 4'd2,
    OP_MOVLI = 4'd3,
    OP_MOVHI = 4'd4,
    OP_ANDI  = 4'd5,
    OP_SHLI  = 4'd6,
    OP_SHRI  = 4'd7,
    OP_BEQI  = 4'd8,
    OP_JMP   = 4'd9,
    OP_BEQ   = 4'd10,
    OP_INCR  = 4'd11,
    OP_ALU   = 4'd12,
    OP_LOAD  = 4'd13,
    OP_STORE = 4'd14,
    OP_SH    = 4'd15
  } op_e;

  // Encoder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam int c_word_w = 9;

  // Legal ALU funct codes
  localparam logic [3:0] c_funct_add = 4'b0001;
  localparam logic [3:0] c_funct_sub = 4'b0010;
  localparam logic [3:0] c_funct_and = 4'b0011;
  localparam logic [3:0] c_funct_or  = 4'b0100;
  localparam logic [3:0] c_funct_xor = 4'b0110;

  // Fixed words
  localparam logic [c_word_w-1:0] c_enc_nil  = 9'b000000000;
  localparam logic [c_word_w-1:0] c_enc_halt = 9'b000000001;

  // Opcode prefixes, most significant bits of the encoded word
  localparam logic [2:0] c_pfx_jmpi  = 3'b111;
  localparam logic [2:0] c_pfx_movli = 3'b100;
  localparam logic [2:0] c_pfx_movhi = 3'b101;
  localparam logic [2:0] c_pfx_andi  = 3'b110;
  localparam logic [3:0] c_pfx_shli  = 4'b0110;
  localparam logic [3:0] c_pfx_shri  = 4'b0111;
  localparam logic [5:0] c_pfx_beqi  = 6'b001011;
  localparam logic [6:0] c_pfx_jmp   = 7'b0000010;
  localparam logic [6:0] c_pfx_beq   = 7'b0000001;
  localparam logic [6:0] c_pfx_incr  = 7'b0000011;
  localparam logic       c_pfx_alu   = 1'b0;
  localparam logic [4:0] c_pfx_load  = 5'b01000;
  localparam logic [4:0] c_pfx_store = 5'b01001;
  localparam logic [4:0] c_pfx_sh    = 5'b00111;

  // True when the funct code names an implemented ALU operation
  function automatic logic funct_legal(input logic [3:0] funct);
    return (funct == c_funct_add) || (funct == c_funct_sub) ||
           (funct == c_funct_and) || (funct == c_funct_or)  ||
           (funct == c_funct_xor);
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : enc_fifo
// Description : Synchronous FIFO for encoded instruction words. Head is
//               presented combinationally from storage; a push while full is
//               taken only when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_ptr_one = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next storage contents and pointer values
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d                   = wr_ptr_q + c_ptr_one;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
  end

  // Storage and pointer registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Encodes instruction fields into 9-bit words, buffers them and
//               writes them to consecutive instruction-memory addresses.
//               Illegal fields are swallowed and flagged; HALT ends a run.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
  import cirno_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [1:0]          in_rx,
  input  logic [1:0]          in_ry,
  input  logic [3:0]          in_funct,
  input  logic [5:0]          in_imm,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [c_word_w-1:0] mem_wdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  enc_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic                error_q, error_d;

  op_e                 op;
  logic [c_word_w-1:0] enc_word;
  logic                enc_legal;
  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [c_word_w-1:0] fifo_head;

  assign op = op_e'(in_op);

  // Field-to-word encoding and legality check for the presented instruction
  always_comb begin
    enc_word  = c_enc_nil;
    enc_legal = 1'b1;
    case (op)
      OP_NIL:   enc_word = c_enc_nil;
      OP_HALT:  enc_word = c_enc_halt;
      OP_JMPI:  enc_word = {c_pfx_jmpi, in_imm};
      OP_MOVLI: begin
        enc_word  = {c_pfx_movli, in_rx, in_imm[3:0]};
        enc_legal = (in_imm[5:4] == 2'b00);
      end
      OP_MOVHI: begin
        enc_word  = {c_pfx_movhi, in_rx, in_imm[3:0]};
        enc_legal = (in_imm[5:4] == 2'b00);
      end
      OP_ANDI:  begin
        enc_word  = {c_pfx_andi, in_rx, in_imm[3:0]};
        enc_legal = (in_imm[5:4] == 2'b00);
      end
      OP_SHLI:  begin
        enc_word  = {c_pfx_shli, in_rx, in_imm[2:0]};
        enc_legal = (in_imm[5:3] == 3'b000);
      end
      OP_SHRI:  begin
        enc_word  = {c_pfx_shri, in_rx, in_imm[2:0]};
        enc_legal = (in_imm[5:3] == 3'b000);
      end
      OP_BEQI:  begin
        enc_word  = {c_pfx_beqi, in_imm[2:0]};
        enc_legal = (in_imm[5:3] == 3'b000);
      end
      OP_JMP:   enc_word = {c_pfx_jmp, in_rx};
      OP_BEQ:   enc_word = {c_pfx_beq, in_rx};
      OP_INCR:  enc_word = {c_pfx_incr, in_rx};
      OP_ALU:   begin
        enc_word  = {c_pfx_alu, in_funct, in_rx, in_ry};
        enc_legal = funct_legal(in_funct);
      end
      OP_LOAD:  enc_word = {c_pfx_load, in_rx, in_ry};
      OP_STORE: enc_word = {c_pfx_store, in_rx, in_ry};
      OP_SH:    enc_word = {c_pfx_sh, in_rx, in_ry};
      default:  enc_word = c_enc_nil;
    endcase
  end

  // Sequencing: handshake, enqueue, memory write side and status
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    error_d   = error_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          wptr_d  = base_addr;
          error_d = 1'b0;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = !fifo_full;
        mem_we   = !fifo_empty;
        if (in_valid && in_ready) begin
          if (enc_legal) begin
            fifo_push = 1'b1;
            if (op == OP_HALT) begin
              state_d = ST_DRAIN;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        mem_we = !fifo_empty;
        // HALT is the last word queued, so writing it finishes the run
        if (mem_we && mem_ready && (fifo_head == c_enc_halt)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_RUN;
          wptr_d  = base_addr;
          error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fifo_pop = mem_we && mem_ready;
    if (fifo_pop) begin
      wptr_d = wptr_q + c_addr_one;
    end
  end

  // State, write pointer and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      error_q <= error_d;
    end
  end

  assign mem_addr  = wptr_q;
  assign mem_wdata = mem_we ? fifo_head : c_enc_nil;
  assign error     = error_q;

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_word_w)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (enc_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder: queue-based reference
//               model compared every cycle, directed scenarios with literal
//               expectations, and randomized sessions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
  import cirno_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [1:0]    in_rx;
  logic [1:0]    in_ry;
  logic [3:0]    in_funct;
  logic [5:0]    in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_wdata;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic          error;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done
  int            m_ph  = 0;
  logic [AW-1:0] m_ptr = '0;
  bit            m_err = 1'b0;
  int            m_q[$];
  // Writes observed on the memory port, for directed checks
  int            log_addr[$];
  int            log_data[$];

  bit rnd_mode  = 1'b0;
  bit rnd_start = 1'b0;

  bit e_ready, e_we, e_pop, e_push, e_legal, e_halt;
  int e_word;

  inst_encoder #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rx     (in_rx),
    .in_ry     (in_ry),
    .in_funct  (in_funct),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the instruction-set table, as field weights
  function automatic void model_enc(input int op, input int rx, input int ry,
                                    input int funct, input int imm,
                                    output int word, output bit legal, output bit halt);
    word  = 0;
    legal = 1'b1;
    halt  = 1'b0;
    case (op)
      0:  word = 0;
      1:  begin word = 1; halt = 1'b1; end
      2:  word = 7 * 64 + imm;
      3:  begin word = 4 * 64 + rx * 16 + imm; legal = (imm < 16); end
      4:  begin word = 5 * 64 + rx * 16 + imm; legal = (imm < 16); end
      5:  begin word = 6 * 64 + rx * 16 + imm; legal = (imm < 16); end
      6:  begin word = 6 * 32 + rx * 8 + imm; legal = (imm < 8); end
      7:  begin word = 7 * 32 + rx * 8 + imm; legal = (imm < 8); end
      8:  begin word = 11 * 8 + imm; legal = (imm < 8); end
      9:  word = 2 * 4 + rx;
      10: word = 1 * 4 + rx;
      11: word = 3 * 4 + rx;
      12: begin
        word  = funct * 16 + rx * 4 + ry;
        legal = (funct == 1) || (funct == 2) || (funct == 3) || (funct == 4) || (funct == 6);
      end
      13: word = 8 * 16 + rx * 4 + ry;
      14: word = 9 * 16 + rx * 4 + ry;
      default: word = 7 * 16 + rx * 4 + ry;
    endcase
  endfunction

  // Per-cycle comparison against the model, then advance the model one edge
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ph  = 0;
      m_ptr = '0;
      m_err = 1'b0;
      m_q.delete();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
    end else begin
      e_ready = (m_ph == 1) && (m_q.size() < DEPTH);
      e_we    = ((m_ph == 1) || (m_ph == 2)) && (m_q.size() > 0);
      chk("in_ready", in_ready, e_ready);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, m_ptr);
      chk("busy", busy, (m_ph == 1) || (m_ph == 2));
      chk("done", done, m_ph == 3);
      chk("error", error, m_err);
      if (e_we) chk("mem_wdata", mem_wdata, m_q[0]);
      if (mem_we && mem_ready) begin
        log_addr.push_back(int'(mem_addr));
        log_data.push_back(int'(mem_wdata));
      end
      e_pop  = e_we && mem_ready;
      e_push = 1'b0;
      case (m_ph)
        0: if (start) begin m_ph = 1; m_ptr = base_addr; m_err = 1'b0; end
        1: if (in_valid && e_ready) begin
          model_enc(int'(in_op), int'(in_rx), int'(in_ry), int'(in_funct), int'(in_imm),
                    e_word, e_legal, e_halt);
          if (e_legal) begin
            e_push = 1'b1;
            if (e_halt) m_ph = 2;
          end else begin
            m_err = 1'b1;
          end
        end
        2: if (e_pop && (m_q[0] == 1)) m_ph = 3;
        default: if (start) begin m_ph = 1; m_ptr = base_addr; m_err = 1'b0; end
      endcase
      if (e_pop) begin
        void'(m_q.pop_front());
        m_ptr = m_ptr + 1'b1;
      end
      if (e_push) m_q.push_back(e_word);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode)  mem_ready = ($urandom_range(0, 3) != 0);
    if (rnd_start) start = ($urandom_range(0, 5) == 0);
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                      input logic [3:0] funct, input logic [5:0] imm);
    bit acc;
    acc = 1'b0;
    if (rnd_mode) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1;
    in_op    = op;
    in_rx    = rx;
    in_ry    = ry;
    in_funct = funct;
    in_imm   = imm;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic chk_log(input string name, input int idx, input int a, input int d);
    if (idx >= log_addr.size()) begin
      chk({name, "_missing"}, log_addr.size(), idx + 1);
    end else begin
      chk({name, "_addr"}, log_addr[idx], a);
      chk({name, "_data"}, log_data[idx], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int n;
    logic [3:0] op;
    logic [5:0] imm;

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rx     = '0;
    in_ry     = '0;
    in_funct  = '0;
    in_imm    = '0;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // MOVHI then HALT from base 0x10
    b = log_addr.size();
    do_start(8'h10);
    push(OP_MOVHI, 2'd2, 2'd0, 4'd0, 6'd5);
    push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
    wait_done("halt_done");
    chk_log("movhi", b, 'h10, 'b101100101);
    chk_log("halt", b + 1, 'h11, 'b000000001);

    // Illegal immediate and funct are swallowed; legal words follow
    b = log_addr.size();
    do_start(8'h20);
    push(OP_ANDI, 2'd1, 2'd0, 4'd0, 6'd20);
    chk("andi_error", error, 1);
    push(OP_INCR, 2'd3, 2'd0, 4'd0, 6'd0);
    push(OP_ALU, 2'd1, 2'd2, 4'b0011, 6'd0);
    push(OP_ALU, 2'd1, 2'd2, 4'b1100, 6'd0);
    push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
    wait_done("err_done");
    chk_log("incr", b, 'h20, 'b000001111);
    chk_log("alu", b + 1, 'h21, 'b000110110);
    chk_log("err_halt", b + 2, 'h22, 1);
    chk("err_sticky", error, 1);

    // Back-pressure: FIFO fills at four, all five written after release
    b = log_addr.size();
    mem_ready = 1'b0;
    do_start(8'h40);
    chk("start_clears_error", error, 0);
    for (int i = 1; i <= 4; i++) push(OP_JMPI, 2'd0, 2'd0, 4'd0, 6'(i));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    tick();
    tick();
    chk("full_no_write", log_addr.size(), b);
    mem_ready = 1'b1;
    push(OP_JMPI, 2'd0, 2'd0, 4'd0, 6'd5);
    push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
    wait_done("bp_done");
    for (int i = 0; i < 5; i++) chk_log("bp_word", b + i, 'h40 + i, 'h1C1 + i);

    // Address wrap past the top of memory
    b = log_addr.size();
    do_start(8'hFE);
    for (int i = 0; i < 3; i++) push(OP_JMPI, 2'd0, 2'd0, 4'd0, 6'(i));
    push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
    wait_done("wrap_done");
    chk_log("wrap0", b, 'hFE, 'h1C0);
    chk_log("wrap1", b + 1, 'hFF, 'h1C1);
    chk_log("wrap2", b + 2, 'h00, 'h1C2);
    chk_log("wrap_halt", b + 3, 'h01, 1);

    // Randomized sessions checked by the per-cycle model
    for (int s = 0; s < 12; s++) begin
      rnd_mode = 1'b1;
      do_start(AW'($urandom_range(0, 255)));
      rnd_start = 1'b1;
      n = $urandom_range(3, 20);
      for (int k = 0; k < n; k++) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_HALT) op = OP_NIL;
        imm = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        push(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), imm);
      end
      push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
      rnd_start = 1'b0;
      start     = 1'b0;
      wait_done("rnd_done");
    end
    rnd_mode  = 1'b0;
    mem_ready = 1'b1;

    // Reset while draining with a write pending
    mem_ready = 1'b0;
    do_start(8'h80);
    push(OP_NIL, 2'd0, 2'd0, 4'd0, 6'd0);
    push(OP_MOVLI, 2'd1, 2'd0, 4'd0, 6'd3);
    push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
    chk("drain_busy", busy, 1);
    chk("drain_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    tick();
    tick();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_no_we", mem_we, 0);
    b = log_addr.size();
    do_start(8'h05);
    push(OP_HALT, 2'd0, 2'd0, 4'd0, 6'd0);
    wait_done("post_rst_done");
    chk_log("post_rst_halt", b, 'h05, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, encoded-word buffer depth (power of two, >=2).
REQ-002 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  pulse; loads base_addr and enters RUN.
REQ-006 base_addr  in  ADDR_W  first write address.
REQ-007 in_valid / in_ready  in / out  1  instruction-field handshake.
REQ-008 in_op  in  4  op code from shared enum.
REQ-009 in_rx, in_ry  in  2 each  register fields.
REQ-010 in_funct  in  4  ALU funct, used for OP_ALU only.
REQ-011 in_imm  in  6  immediate.
REQ-012 mem_we  out  1  instruction-memory write strobe.
REQ-013 mem_addr  out  ADDR_W  write address.
REQ-014 mem_wdata  out  9  encoded instruction.
REQ-015 mem_ready  in  1  memory accepts the write this cycle.
REQ-016 busy, done, error  out  1 each  status.

Function
REQ-017 Encoding (bit 8..0): NIL 000000000; HALT 000000001; JMPI 111,imm[5:0]; MOVLI 100,rx,imm[3:0]; MOVHI 101,rx,imm[3:0]; ANDI 110,rx,imm[3:0]; SHLI 0110,rx,imm[2:0]; SHRI 0111,rx,imm[2:0]; BEQI 001011,imm[2:0]; JMP 0000010,rx; BEQ 0000001,rx; INCR 0000011,rx; ALU 0,funct,rx,ry; LOAD 01000,rx,ry; STORE 01001,rx,ry; SH 00111,rx,ry.
REQ-018 Legal ALU funct: 0001, 0010, 0011, 0100, 0110; any other is illegal.
REQ-019 Illegal: imm>15 for MOVLI/MOVHI/ANDI, imm>7 for SHLI/SHRI/BEQI, illegal funct; illegal input is accepted, not enqueued, error set sticky.
REQ-020 States IDLE, RUN, DRAIN, DONE; reset -> IDLE.
REQ-021 IDLE: in_ready=0; start -> RUN, write pointer <= base_addr.
REQ-022 RUN: in_ready = FIFO not full; transfer when in_valid&in_ready; legal word enqueued same edge.
REQ-023 Accepting a legal HALT enqueues it and moves to DRAIN; in_ready=0 in DRAIN.
REQ-024 Write side: mem_we = FIFO not empty in RUN/DRAIN; mem_wdata = FIFO head, mem_addr = write pointer; on mem_we&mem_ready pop and increment pointer.
REQ-025 Pointer wraps modulo 2^ADDR_W silently.
REQ-026 DRAIN -> DONE on the edge the HALT word is written; done=1 in DONE; start in DONE re-enters RUN with new base_addr and clears error.
REQ-027 start in RUN or DRAIN ignored.
REQ-028 Simultaneous push and pop when full: allowed only if pop occurs; in_ready stays computed from pre-edge full (no bypass).
REQ-029 Latency: accepted word appears on mem_wdata with mem_we the cycle after acceptance at earliest.
REQ-030 busy=1 in RUN and DRAIN.

Reset
REQ-031 rst_n low clears FIFO, pointer=0, state IDLE, mem_we=0, mem_wdata=0, mem_addr=0, in_ready=0, busy=done=error=0, immediately, mid-write included.

Structure
REQ-032 Package cirno_pkg holds op enum (OP_NIL..OP_SH, 4 bits), funct constants and encoding field constants; shared with decoder.
REQ-033 One sub-module: enc_fifo (synchronous FIFO, FIFO_DEPTH x 9); encoding combinational in inst_encoder.

Verification
REQ-034 start base 0x10; push MOVHI rx=2 imm=5, HALT with mem_ready=1 -> writes 0x10:1_01_10_0101, 0x11:000000001, done=1.
REQ-035 Push ANDI imm=20 -> no write, error=1; following legal INCR rx=3 written as 000001111.
REQ-036 mem_ready=0, push 5 words -> in_ready=0 after 4; release -> 5 in-order writes, none lost.
REQ-037 base 0xFE, 3 JMPI -> addresses 0xFE, 0xFF, 0x00.
REQ-038 rst_n low during DRAIN with mem_we=1 -> all outputs zero same cycle, IDLE after release.
REQ-039 ALU funct 0011 rx=1 ry=2 -> 000110110; funct 1100 -> error, no write.
